muldiv_seq: RTL and testbench

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_seq_if.sv | 18 +
 rtl/muldiv_seq.sv | 143 ++++++++++++++
 tb/tb_muldiv_seq.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_if.sv
// Execute-stage port bundle for muldiv_seq: instruction/operands in, busy/done/result out.
interface muldiv_seq_if #(
  parameter int XLEN = 64
);
  logic            valid;
  logic [2:0]      func;
  logic            word;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            stall;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output valid, func, word, a, b, stall, flush, input busy, done, result);
  modport slave  (input valid, func, word, a, b, stall, flush, output busy, done, result);
endinterface

// File: rtl/muldiv_seq.sv
// Sequential RV64 M-unit: radix-2 shift-add multiply, restoring divide; done N+1 cycles after accept
// (N=XLEN, or 32 for W-forms), div-by-zero/overflow finish in 1; stall holds DONE, flush aborts.
module muldiv_seq #(
  parameter int XLEN = 64
) (
  input logic         clk,
  input logic         reset,
  muldiv_seq_if.slave bus
);
  localparam int CW = $clog2(XLEN) + 1;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            word_q, neg_q, neg_r, is_rem, done_q;
  logic [XLEN-1:0] mcand, mplier, acc, dvsr, quo, result_q;
  logic [XLEN:0]   rem;

  logic            is_div, sgn, accept, a_neg, b_neg, b_zero, ovf;
  logic [XLEN-1:0] a_op, b_op, a_mag, b_mag, a_fix, special;
  logic [XLEN-1:0] acc_nxt, quo_nxt, q_fin, r_fin;
  logic [XLEN:0]   shl, diff, rem_nxt;

  function automatic logic [XLEN-1:0] fix(input logic w, input logic [XLEN-1:0] x);
    return w ? {{(XLEN-32){x[31]}}, x[31:0]} : x;
  endfunction

  always_comb begin
    is_div = bus.func inside {3'd1, 3'd2, 3'd3, 3'd4};
    sgn    = (bus.func == 3'd1) || (bus.func == 3'd3);
    accept = (state == IDLE) && bus.valid && (bus.func <= 3'd4) && !bus.flush;
    a_op   = bus.a;
    b_op   = bus.b;
    if (bus.word) begin
      a_op = {{(XLEN-32){sgn & bus.a[31]}}, bus.a[31:0]};
      b_op = {{(XLEN-32){sgn & bus.b[31]}}, bus.b[31:0]};
    end
    a_neg  = sgn && a_op[XLEN-1];
    b_neg  = sgn && b_op[XLEN-1];
    a_mag  = a_neg ? -a_op : a_op;
    b_mag  = b_neg ? -b_op : b_op;
    b_zero = is_div && (b_op == '0);
    if (bus.word)
      ovf = sgn && (bus.a[31:0] == 32'h8000_0000) && (bus.b[31:0] == 32'hFFFF_FFFF);
    else
      ovf = sgn && (bus.a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.b == '1);
    a_fix = fix(bus.word, bus.a);
    // Early-out results: REM/REMU on func 3/4, quotient forms otherwise.
    if (bus.func >= 3'd3)
      special = ovf ? '0 : a_fix;
    else
      special = ovf ? a_fix : '1;

    acc_nxt = acc + (mplier[0] ? mcand : '0);
    // Partial remainder never exceeds the divisor, so XLEN+1 bits catch the borrow.
    shl     = {rem[XLEN-1:0], quo[XLEN-1]};
    diff    = shl - {1'b0, dvsr};
    rem_nxt = diff[XLEN] ? shl : diff;
    quo_nxt = {quo[XLEN-2:0], ~diff[XLEN]};
    q_fin   = neg_q ? -quo_nxt : quo_nxt;
    r_fin   = neg_r ? -rem_nxt[XLEN-1:0] : rem_nxt[XLEN-1:0];
  end

  assign bus.busy   = !reset && (accept || (!bus.flush && (state == MUL || state == DIV)));
  assign bus.done   = done_q;
  assign bus.result = result_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      word_q   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      is_rem   <= 1'b0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      dvsr     <= '0;
      quo      <= '0;
      rem      <= '0;
    end else if (bus.flush) begin
      state  <= IDLE;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          word_q <= bus.word;
          neg_q  <= a_neg ^ b_neg;
          neg_r  <= a_neg;
          is_rem <= bus.func >= 3'd3;
          cnt    <= bus.word ? CW'(32) : CW'(XLEN);
          mcand  <= a_op;
          mplier <= b_op;
          acc    <= '0;
          dvsr   <= b_mag;
          rem    <= '0;
          // W-form dividend sits at the top so every step consumes quo[XLEN-1].
          quo    <= bus.word ? (a_mag << (XLEN-32)) : a_mag;
          if (!is_div) begin
            state <= MUL;
          end else if (b_zero || ovf) begin
            state    <= DONE;
            cnt      <= '0;
            done_q   <= 1'b1;
            result_q <= special;
          end else begin
            state <= DIV;
          end
        end
        MUL: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state    <= DONE;
            done_q   <= 1'b1;
            result_q <= fix(word_q, acc_nxt);
          end
        end
        DIV: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state    <= DONE;
            done_q   <= 1'b1;
            result_q <= fix(word_q, is_rem ? r_fin : q_fin);
          end
        end
        DONE: if (!bus.stall) begin
          state  <= IDLE;
          done_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized scoreboard bench for muldiv_seq against an arithmetic reference model.
module tb_muldiv_seq;
  localparam int XLEN = 64;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_seq_if #(.XLEN(XLEN)) bus ();
  muldiv_seq #(.XLEN(XLEN)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [63:0] res;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic done_d   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain RV64 M semantics including the divide-by-zero and overflow rules.
  function automatic void model(input logic [2:0] f, input bit w, input logic [63:0] a,
                                input logic [63:0] b, output logic [63:0] r, output int lat);
    longint sa, sb;
    longint unsigned ua, ub;
    int sa32, sb32;
    int unsigned ua32, ub32;
    logic [31:0] r32;
    bit bz, ov;
    sa = a; sb = b; ua = a; ub = b;
    sa32 = a[31:0]; sb32 = b[31:0]; ua32 = a[31:0]; ub32 = b[31:0];
    bz  = w ? (b[31:0] == 32'd0) : (b == 64'd0);
    ov  = w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) : (a == MINV && b == '1);
    lat = w ? 33 : 65;
    r   = '0;
    r32 = '0;
    if (f != 3'd0 && (bz || (ov && (f == 3'd1 || f == 3'd3)))) lat = 1;
    if (w) begin
      case (f)
        3'd0: r32 = 32'(sa32 * sb32);
        3'd1: r32 = bz ? 32'hFFFF_FFFF : ov ? a[31:0] : 32'(sa32 / sb32);
        3'd2: r32 = bz ? 32'hFFFF_FFFF : 32'(ua32 / ub32);
        3'd3: r32 = bz ? a[31:0] : ov ? 32'd0 : 32'(sa32 % sb32);
        default: r32 = bz ? a[31:0] : 32'(ua32 % ub32);
      endcase
      r = {{32{r32[31]}}, r32};
    end else begin
      case (f)
        3'd0: r = 64'(sa * sb);
        3'd1: r = bz ? '1 : ov ? a : 64'(sa / sb);
        3'd2: r = bz ? '1 : 64'(ua / ub);
        3'd3: r = bz ? a : ov ? 64'd0 : 64'(sa % sb);
        default: r = bz ? a : 64'(ua % ub);
      endcase
    end
  endfunction

  // Monitor: one scoreboard pop per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (bus.done && !done_d) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", bus.done, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("result", bus.result, e.res);
        check("done_cycle", 64'(cyc), 64'(e.due));
      end
    end
    done_d <= bus.done;
  end

  // Entered at a negedge; holds valid like the pipeline until the DONE cycle retires.
  task automatic run_op(input logic [2:0] f, input bit w, input logic [63:0] a,
                        input logic [63:0] b, input int stall_n);
    logic [63:0] er;
    int lat, busy_n, t;
    exp_t e;
    model(f, w, a, b, er, lat);
    bus.valid = 1'b1; bus.func = f; bus.word = w; bus.a = a; bus.b = b;
    bus.stall = (stall_n > 0);
    e.res = er;
    e.due = cyc + lat;
    exp_q.push_back(e);
    busy_n = 0;
    t = 0;
    #1;
    while (!bus.done && t < 200) begin
      if (bus.busy) busy_n++;
      @(negedge clk); #1;
      t++;
    end
    if (t >= 200) begin
      check("done_timeout", bus.done, 1'b1);
    end else begin
      check("busy_cycles", 64'(busy_n), 64'(lat));
      for (int i = 0; i < stall_n; i++) begin
        check("stall_done", bus.done, 1'b1);
        check("stall_result", bus.result, er);
        @(negedge clk); #1;
      end
      bus.stall = 1'b0;
      check("exit_done", bus.done, 1'b1);
      @(negedge clk);
      bus.valid = 1'b0;
      #1;
      check("idle_done", bus.done, 1'b0);
      check("idle_busy", bus.busy, 1'b0);
      check("hold_result", bus.result, er);
    end
  endtask

  initial begin
    logic [63:0] ra, rb;
    bit seen;
    bus.valid = 1'b1; bus.func = 3'd0; bus.word = 1'b0; bus.a = 64'd3; bus.b = 64'd5;
    bus.stall = 1'b0; bus.flush = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_result", bus.result, 64'd0);
    @(negedge clk);
    bus.valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);

    // Directed cases, issued back to back.
    run_op(3'd0, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 0);
    run_op(3'd1, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 0);
    run_op(3'd3, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 0);
    run_op(3'd2, 1'b0, 64'd100, 64'd0, 0);
    run_op(3'd4, 1'b0, 64'd100, 64'd0, 0);
    run_op(3'd1, 1'b0, MINV, '1, 0);
    run_op(3'd3, 1'b0, MINV, '1, 0);
    run_op(3'd0, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 5);

    // Reserved functions are ignored.
    for (int f = 5; f < 8; f++) begin
      bus.valid = 1'b1; bus.func = 3'(f);
      #1;
      check("reserved_busy", bus.busy, 1'b0);
      @(negedge clk);
    end
    bus.valid = 1'b0;
    repeat (3) @(negedge clk);
    check("reserved_done", bus.done, 1'b0);

    // Flush at iteration 10 of a divide.
    bus.valid = 1'b1; bus.func = 3'd1; bus.word = 1'b0;
    bus.a = {$urandom, $urandom}; bus.b = 64'd7;
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    #1;
    check("flush_busy", bus.busy, 1'b0);
    @(negedge clk);
    bus.flush = 1'b0;
    bus.valid = 1'b0;
    #1;
    check("post_flush_busy", bus.busy, 1'b0);
    seen = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    check("flush_no_done", seen, 1'b0);

    // Reset at iteration 20 of a multiply with valid held; it must restart cleanly.
    ra = {$urandom, $urandom};
    rb = {$urandom, $urandom};
    bus.valid = 1'b1; bus.func = 3'd0; bus.word = 1'b0; bus.a = ra; bus.b = rb;
    repeat (20) @(negedge clk);
    #1;
    check("pre_reset_busy", bus.busy, 1'b1);
    reset = 1'b1;
    #1;
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_done", bus.done, 1'b0);
    check("midrst_result", bus.result, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run_op(3'd0, 1'b0, ra, rb, 0);

    // Randomized mix with edge-biased operands, idle gaps and stalls.
    for (int i = 0; i < 40; i++) begin
      logic [2:0] f;
      bit w;
      logic [63:0] a, b;
      int sel;
      f = 3'($urandom_range(0, 4));
      w = 1'($urandom_range(0, 1));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        b = w ? {$urandom, 32'd0} : 64'd0;
      end else if (sel == 1) begin
        a = w ? {$urandom, 32'h8000_0000} : MINV;
        b = w ? {$urandom, 32'hFFFF_FFFF} : '1;
      end else if (sel == 2) begin
        b = 64'($urandom_range(1, 15));
      end else if (sel == 3) begin
        b = -64'($urandom_range(1, 15));
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op(f, w, a, b, $urandom_range(0, 2));
    end

    repeat (3) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
